dice_ram_1w1r_pipe: RTL
=======================

# dice_ram_1w1r_pipe

Parametrised one-write/one-read RAM for DICE datapath buffers. Adds per-byte write enables, a configurable read pipeline with a valid strobe, and defined read-during-write forwarding, plus an optional reset-time zero-initialisation sweep. Sits wherever DICE needs a simple dual-port store with a registered, pipelined read and predictable collision behaviour.

## Interface
- DATA_WIDTH, 32: word width; must be a multiple of BYTE_WIDTH
- BYTE_WIDTH, 8: width of one write-enable lane
- DEPTH, 1024: number of words; need not be a power of two
- ADDR_WIDTH, $clog2(DEPTH): address width
- RD_LATENCY, 1: cycles from accepted rd_en to rd_valid; legal range 1..3
- WR_FWD, 1: 1 = same-cycle same-address read returns new data; 0 = returns old data
- NUM_BYTES (derived), DATA_WIDTH/BYTE_WIDTH
- clk  in  1  clock; all logic on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- init_done  out  1  RAM accepts accesses
- wr_en  in  1  write request
- wr_addr  in  ADDR_WIDTH  write address
- wr_data  in  DATA_WIDTH  write data
- wr_be  in  NUM_BYTES  byte-lane enables; lane b covers bits [b*BYTE_WIDTH +: BYTE_WIDTH]
- rd_en  in  1  read request
- rd_addr  in  ADDR_WIDTH  read address
- rd_valid  out  1  rd_data carries the result of a read
- rd_data  out  DATA_WIDTH  read result; holds last value when rd_valid=0

## Operation
- Write: on a clock edge with wr_en=1, init_done=1, wr_addr<DEPTH, each lane with wr_be[b]=1 updates; other lanes keep old contents. wr_be=0 is a no-op.
- Read: rd_en=1 with init_done=1 samples the array at that edge; the result emerges with rd_valid=1 exactly RD_LATENCY cycles later. Back-to-back reads fully pipelined, one per cycle.
- Collision (rd_en, wr_en, same address, same edge): WR_FWD=1 returns the byte-merged word (new bytes on enabled lanes, old elsewhere); WR_FWD=0 returns pre-write contents.
- Result reflects array state at the sampling edge; writes after that edge do not alter reads already in the pipeline.
- Out-of-range address (addr>=DEPTH): write dropped; read still produces rd_valid with rd_data=0.
- wr_en/rd_en while init_done=0: ignored; no rd_valid generated.
- Reset: rd_valid=0, rd_data=0, all pipeline valids cleared, init_done=0. Array contents unaffected by reset unless the init feature is compiled in. Reset mid-pipeline discards in-flight reads.

## Timing
- Write-to-read: data written at edge N is visible to a read sampled at edge N+1 (or at edge N with WR_FWD=1).
- Read sampled at edge N → rd_valid=1, rd_data valid after edge N+RD_LATENCY, for one cycle per read.
- rd_data changes only on edges where a valid result is delivered.
- init_done timing given under Configuration.

## Configuration
- Macro DICE_RAM_INIT_ZERO_EN.
- Defined: two-state FSM INIT→READY. Reset enters INIT with sweep counter 0. Each edge in INIT writes all-zero to address counter and increments; on the edge writing DEPTH-1, go to READY. init_done=1 in READY only, i.e. after edge DEPTH following reset release. Reset asserted at any point returns to INIT, counter 0; sweep restarts fully.
- Undefined: no sweep, no FSM storage. init_done=0 in reset, 1 after the first edge following rst_n release. Array power-up contents undefined (X in simulation).

## Structure
- Package dice_ram_pkg: INIT/READY state enum typedef, RD_LATENCY bounds constants, NUM_BYTES helper function; static elaboration check that DATA_WIDTH%BYTE_WIDTH==0 and 1<=RD_LATENCY<=3.
- Sub-module dice_ram_rd_pipe: valid+data shift stages (RD_LATENCY-1 extra stages after the array read register), async-reset valids, hold-on-invalid output register.

## Test plan
- DEPTH=16, macro on: release reset, check init_done=0 for 16 edges then 1; read all 16 addresses → rd_data=0, rd_valid after RD_LATENCY each.
- Write 0xDEADBEEF to addr 5 with wr_be=4'hF, then wr_data=0x11223344 wr_be=4'b0101 → read addr 5 returns 0xDE22BE44.
- Same-edge write 0xCAFEF00D / read addr 3 (old 0x0) with WR_FWD=1 → 0xCAFEF00D; WR_FWD=0 → 0x00000000; next read → 0xCAFEF00D.
- RD_LATENCY=3, reads to addr 0..7 on consecutive edges → 8 consecutive rd_valid pulses starting 3 edges after first, data in order.
- DEPTH=12: write addr 13 dropped (addr 1 unchanged, no alias); read addr 13 → rd_valid=1, rd_data=0.
- Assert rst_n=0 mid-sweep (counter 7) and with 2 reads in flight → rd_valid=0, rd_data=0 immediately; sweep restarts, init_done after 16 further edges; accesses during sweep ignored.

Source files
------------

// File: rtl/dice_ram_pkg.sv
// dice_ram_pkg: shared types and constants for the DICE 1W1R RAM.
//   init_state_e : zero-init sweep states (only used with DICE_RAM_INIT_ZERO_EN)
//   RD_LAT_MIN/MAX : legal range of the read pipeline depth
//   num_bytes()  : byte-lane count for a given word/lane width
package dice_ram_pkg;
  typedef enum logic {ST_INIT = 1'b0, ST_READY = 1'b1} init_state_e;

  localparam int RD_LAT_MIN = 1;
  localparam int RD_LAT_MAX = 3;

  function automatic int num_bytes(input int data_w, input int byte_w);
    return data_w / byte_w;
  endfunction
endpackage

// File: rtl/dice_ram_1w1r_pipe_if.sv
// dice_ram_1w1r_pipe_if: write/read access bundle for dice_ram_1w1r_pipe.
//   master : drives wr_en/wr_addr/wr_data/wr_be and rd_en/rd_addr,
//            receives init_done/rd_valid/rd_data
//   slave  : the RAM side of the same signals
interface dice_ram_1w1r_pipe_if
  import dice_ram_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int BYTE_WIDTH = 8,
  parameter int ADDR_WIDTH = 10
);
  localparam int NUM_BYTES = num_bytes(DATA_WIDTH, BYTE_WIDTH);

  logic                  init_done;
  logic                  wr_en;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic [NUM_BYTES-1:0]  wr_be;
  logic                  rd_en;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic                  rd_valid;
  logic [DATA_WIDTH-1:0] rd_data;

  modport master (
    output wr_en, wr_addr, wr_data, wr_be, rd_en, rd_addr,
    input  init_done, rd_valid, rd_data
  );
  modport slave (
    input  wr_en, wr_addr, wr_data, wr_be, rd_en, rd_addr,
    output init_done, rd_valid, rd_data
  );
endinterface

// File: rtl/dice_ram_rd_pipe.sv
// dice_ram_rd_pipe: read-result pipeline behind the RAM array.
//   Stage 0 is the array read register; STAGES further stages follow.
//   Every stage only loads when a valid result enters it, so the last
//   stage (the output) holds its value while out_vld is low.
//   clk, rst_n       : clock, async active-low reset (clears valids and data)
//   in_vld, in_data  : accepted read and the word sampled at this edge
//   out_vld, out_data: delivered result
module dice_ram_rd_pipe #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_vld,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_vld,
  output logic [WIDTH-1:0] out_data
);
  logic [STAGES:0]            vld_pipe;
  logic [STAGES:0][WIDTH-1:0] dat_pipe;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe <= '0;
      dat_pipe <= '0;
    end else begin
      vld_pipe[0] <= in_vld;
      if (in_vld) dat_pipe[0] <= in_data;
      for (int k = 1; k <= STAGES; k++) begin
        vld_pipe[k] <= vld_pipe[k-1];
        if (vld_pipe[k-1]) dat_pipe[k] <= dat_pipe[k-1];
      end
    end
  end

  assign out_vld  = vld_pipe[STAGES];
  assign out_data = dat_pipe[STAGES];
endmodule

// File: rtl/dice_ram_1w1r_pipe.sv
// dice_ram_1w1r_pipe: one-write/one-read RAM with byte enables, a
// RD_LATENCY-deep registered read pipeline and defined collision behaviour.
//   clk, rst_n : clock, async active-low reset
//   bus        : dice_ram_1w1r_pipe_if.slave (write port, read port,
//                init_done, rd_valid/rd_data)
// A read with rd_en high in cycle c delivers rd_valid in cycle c+RD_LATENCY.
// Out-of-range writes are dropped; out-of-range reads return zero.
// Optional macro DICE_RAM_INIT_ZERO_EN: after reset an INIT/READY FSM sweeps
// zeros through every word; init_done rises only once the sweep completes.
// Without it, init_done rises on the first edge after reset release.
module dice_ram_1w1r_pipe
  import dice_ram_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int BYTE_WIDTH = 8,
  parameter int DEPTH      = 1024,
  parameter int ADDR_WIDTH = $clog2(DEPTH),
  parameter int RD_LATENCY = 1,
  parameter int WR_FWD     = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  dice_ram_1w1r_pipe_if.slave    bus
);
  localparam int NUM_BYTES = num_bytes(DATA_WIDTH, BYTE_WIDTH);
  localparam logic [ADDR_WIDTH:0] DEPTH_L = (ADDR_WIDTH+1)'(DEPTH);

  if ((DATA_WIDTH % BYTE_WIDTH) != 0 || RD_LATENCY < RD_LAT_MIN || RD_LATENCY > RD_LAT_MAX)
  begin : g_bad_cfg
    $error("dice_ram_1w1r_pipe: illegal DATA_WIDTH/BYTE_WIDTH/RD_LATENCY");
  end

  typedef struct packed {
    logic                  we;
    logic [ADDR_WIDTH-1:0] addr;
    logic [NUM_BYTES-1:0]  be;
    logic [DATA_WIDTH-1:0] data;
  } mem_wr_t;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic    init_q;
  logic    wr_ok, rd_ok, rd_in_rng;
  mem_wr_t mem_wr;
  logic [NUM_BYTES-1:0][BYTE_WIDTH-1:0] wr_lanes, rd_old, rd_word;

  assign wr_ok     = bus.wr_en && init_q && ({1'b0, bus.wr_addr} < DEPTH_L);
  assign rd_ok     = bus.rd_en && init_q;
  assign rd_in_rng = {1'b0, bus.rd_addr} < DEPTH_L;
  assign wr_lanes  = bus.wr_data;

`ifdef DICE_RAM_INIT_ZERO_EN
  init_state_e           state;
  logic [ADDR_WIDTH-1:0] sweep_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_INIT;
      sweep_cnt <= '0;
      init_q    <= 1'b0;
    end else if (state == ST_INIT) begin
      if (sweep_cnt == ADDR_WIDTH'(DEPTH-1)) begin
        state  <= ST_READY;
        init_q <= 1'b1;
      end else begin
        sweep_cnt <= sweep_cnt + 1'b1;
      end
    end
  end

  // The sweep owns the write port while INIT; bus writes are gated by init_q.
  always_comb begin
    mem_wr = '{we: wr_ok, addr: bus.wr_addr, be: bus.wr_be, data: bus.wr_data};
    if (state == ST_INIT) mem_wr = '{we: 1'b1, addr: sweep_cnt, be: '1, data: '0};
  end
`else
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) init_q <= 1'b0;
    else        init_q <= 1'b1;
  end

  always_comb begin
    mem_wr = '{we: wr_ok, addr: bus.wr_addr, be: bus.wr_be, data: bus.wr_data};
  end
`endif

  assign bus.init_done = init_q;

  always_ff @(posedge clk) begin
    if (mem_wr.we)
      for (int b = 0; b < NUM_BYTES; b++)
        if (mem_wr.be[b])
          mem[mem_wr.addr][b*BYTE_WIDTH +: BYTE_WIDTH] <= mem_wr.data[b*BYTE_WIDTH +: BYTE_WIDTH];
  end

  assign rd_old = rd_in_rng ? mem[bus.rd_addr] : '0;

  // Collision: the array read naturally returns pre-write contents; with
  // WR_FWD the enabled lanes of the concurrent write are merged in.
  always_comb begin
    rd_word = rd_old;
    if (WR_FWD != 0 && wr_ok && bus.wr_addr == bus.rd_addr)
      for (int b = 0; b < NUM_BYTES; b++)
        if (bus.wr_be[b]) rd_word[b] = wr_lanes[b];
  end

  dice_ram_rd_pipe #(
    .WIDTH  (DATA_WIDTH),
    .STAGES (RD_LATENCY-1)
  ) u_rd_pipe (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_vld   (rd_ok),
    .in_data  (rd_word),
    .out_vld  (bus.rd_valid),
    .out_data (bus.rd_data)
  );
endmodule
